// File: rtl/aurora_pkg.sv
// ---------------------------------------------------------------------------
// aurora_pkg: shared datapath defaults, func3 encodings and ALU op decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aurora_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 4;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // {WRegEn, WMemEn, mem_to_reg} of an EX/MEM bubble; data fields are zeroed too
  localparam logic [2:0] CTRL_BUBBLE = 3'b000;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MULHU, OP_MUL
  } alu_op_e;

  typedef enum logic [0:0] {S_IDLE, S_RUN} ex_state_e;

  // Memory ops always compute an address, whatever func3/func7 say
  function automatic alu_op_e decode_op(input logic [2:0] f3, input logic f7,
                                        input logic is_mem);
    alu_op_e op;
    op = OP_ADD;
    if (!is_mem) begin
      case (f3)
        F3_ADD:  op = f7 ? OP_SUB : OP_ADD;
        F3_SLL:  op = OP_SLL;
        F3_SLT:  op = OP_SLT;
        F3_SLTU: op = OP_SLTU;
        F3_XOR:  op = OP_XOR;
        F3_SR:   op = f7 ? OP_SRA : OP_SRL;
        F3_OR:   op = f7 ? OP_MULHU : OP_OR;
        F3_AND:  op = f7 ? OP_MUL : OP_AND;
        default: op = OP_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// ex_stage_if: ID/EX input bundle, EX/MEM output bundle and stall request
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ex_stage_if
  import aurora_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
);
  logic          WRegEn_in;
  logic          WMemEn_in;
  logic          mem_to_reg_in;
  logic          rs2_swch_in;
  logic [DW-1:0] R1out_in;
  logic [DW-1:0] R2out_in;
  logic [DW-1:0] sign_ext_in;
  logic [RW-1:0] WReg1_in;
  logic [2:0]    func3_in;
  logic          func7_in;

  logic          busy_o;
  logic          WRegEn_out;
  logic          WMemEn_out;
  logic          mem_to_reg_out;
  logic [DW-1:0] alu_res_out;
  logic [DW-1:0] st_data_out;
  logic [RW-1:0] WReg1_out;

  modport master (
    output WRegEn_in, WMemEn_in, mem_to_reg_in, rs2_swch_in, R1out_in,
           R2out_in, sign_ext_in, WReg1_in, func3_in, func7_in,
    input  busy_o, WRegEn_out, WMemEn_out, mem_to_reg_out, alu_res_out,
           st_data_out, WReg1_out
  );

  modport slave (
    input  WRegEn_in, WMemEn_in, mem_to_reg_in, rs2_swch_in, R1out_in,
           R2out_in, sign_ext_in, WReg1_in, func3_in, func7_in,
    output busy_o, WRegEn_out, WMemEn_out, mem_to_reg_out, alu_res_out,
           st_data_out, WReg1_out
  );
endinterface

`default_nettype wire

// File: rtl/seq_mul16.sv
// ---------------------------------------------------------------------------
// seq_mul16: unsigned shift-add multiplier, one partial product per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_mul16
  import aurora_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start_i,
  input  logic            run_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic            done_o,
  output logic [2*DW-1:0] prod_o
);
  localparam int CW = $clog2(DW);

  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [2*DW-1:0] acc_q;
  logic [2*DW-1:0] acc_d;
  logic [2*DW-1:0] addend;
  logic [CW-1:0]   cnt_q;

  // The last partial product is folded in combinationally so the full
  // product is available in the same cycle done_o is raised.
  always_comb begin
    addend = b_q[cnt_q] ? ({{DW{1'b0}}, a_q} << cnt_q) : '0;
    acc_d  = acc_q + addend;
    prod_o = acc_d;
    done_o = run_i && (cnt_q == CW'(DW - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (run_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage: execute stage, EX/MEM latch and multiplier sequencing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_stage
  import aurora_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic     CLK,
  input  logic     RST,
  ex_stage_if.slave bus
);
  ex_state_e       state_q;
  logic            wreg_en_q;
  logic            wmem_en_q;
  logic            m2r_q;
  logic [DW-1:0]   alu_res_q;
  logic [DW-1:0]   st_data_q;
  logic [RW-1:0]   wreg_q;
  logic            mul_hi_q;
  logic [RW-1:0]   mul_wreg_q;

  logic [DW-1:0]   op_b;
  logic [DW-1:0]   alu_res_d;
  alu_op_e         alu_op;
  logic            is_mul;
  logic            mul_start;
  logic            mul_done;
  logic [2*DW-1:0] mul_prod;
  logic [3:0]      shamt;

  always_comb begin
    op_b      = bus.rs2_swch_in ? bus.sign_ext_in : bus.R2out_in;
    alu_op    = decode_op(bus.func3_in, bus.func7_in,
                          bus.WMemEn_in | bus.mem_to_reg_in);
    is_mul    = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
    mul_start = (state_q == S_IDLE) && is_mul && bus.WRegEn_in;
    shamt     = op_b[3:0];
    alu_res_d = '0;
    case (alu_op)
      OP_ADD:  alu_res_d = bus.R1out_in + op_b;
      OP_SUB:  alu_res_d = bus.R1out_in - op_b;
      OP_SLL:  alu_res_d = bus.R1out_in << shamt;
      OP_SLT:  alu_res_d = {{(DW-1){1'b0}}, ($signed(bus.R1out_in) < $signed(op_b))};
      OP_SLTU: alu_res_d = {{(DW-1){1'b0}}, (bus.R1out_in < op_b)};
      OP_XOR:  alu_res_d = bus.R1out_in ^ op_b;
      OP_SRL:  alu_res_d = bus.R1out_in >> shamt;
      OP_SRA:  alu_res_d = $signed(bus.R1out_in) >>> shamt;
      OP_OR:   alu_res_d = bus.R1out_in | op_b;
      OP_AND:  alu_res_d = bus.R1out_in & op_b;
      default: alu_res_d = '0;
    endcase
  end

  seq_mul16 #(.DW(DW)) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .start_i (mul_start),
    .run_i   (state_q == S_RUN),
    .a_i     (bus.R1out_in),
    .b_i     (op_b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Stall drops in the final RUN cycle so upstream advances at the writeback edge
  assign bus.busy_o = !RST && (mul_start || ((state_q == S_RUN) && !mul_done));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q                        <= S_IDLE;
      {wreg_en_q, wmem_en_q, m2r_q}  <= CTRL_BUBBLE;
      alu_res_q                      <= '0;
      st_data_q                      <= '0;
      wreg_q                         <= '0;
      mul_hi_q                       <= 1'b0;
      mul_wreg_q                     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mul) begin
            {wreg_en_q, wmem_en_q, m2r_q} <= CTRL_BUBBLE;
            alu_res_q                     <= '0;
            st_data_q                     <= '0;
            wreg_q                        <= '0;
            if (bus.WRegEn_in) begin
              state_q    <= S_RUN;
              mul_hi_q   <= (alu_op == OP_MULHU);
              mul_wreg_q <= bus.WReg1_in;
            end
          end else begin
            wreg_en_q <= bus.WRegEn_in;
            wmem_en_q <= bus.WMemEn_in;
            m2r_q     <= bus.mem_to_reg_in;
            alu_res_q <= alu_res_d;
            st_data_q <= bus.R2out_in;
            wreg_q    <= bus.WReg1_in;
          end
        end
        S_RUN: begin
          st_data_q <= '0;
          if (mul_done) begin
            state_q                       <= S_IDLE;
            {wreg_en_q, wmem_en_q, m2r_q} <= 3'b100;
            alu_res_q                     <= mul_hi_q ? mul_prod[2*DW-1:DW] : mul_prod[DW-1:0];
            wreg_q                        <= mul_wreg_q;
          end else begin
            {wreg_en_q, wmem_en_q, m2r_q} <= CTRL_BUBBLE;
            alu_res_q                     <= '0;
            wreg_q                        <= '0;
          end
        end
      endcase
    end
  end

  assign bus.WRegEn_out     = wreg_en_q;
  assign bus.WMemEn_out     = wmem_en_q;
  assign bus.mem_to_reg_out = m2r_q;
  assign bus.alu_res_out    = alu_res_q;
  assign bus.st_data_out    = st_data_q;
  assign bus.WReg1_out      = wreg_q;

endmodule

`default_nettype wire
